// File: rtl/decoder_sel_arbiter_pkg.sv
// ============================================================================
// Module   : decoder_sel_arbiter_pkg
// Purpose  : Shared types and constants for the decoder select arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decoder_sel_arbiter_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_e;

   // Round-robin pointer step; the 2-bit width gives the 3->0 wrap for free.
   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return v + IDX_W'(1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_sel_arbiter_rr_pick4.sv
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational 4-way round-robin pick. Rotates the request vector
//            so the pointer position becomes bit 0, priority-encodes the
//            lowest set bit, then adds the pointer back to un-rotate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
   import decoder_sel_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [IDX_W-1:0]     rot_off;

   // Doubling the vector lets a plain part-select act as a rotate.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[{1'b0, ptr} +: NUM_REQ];

   // Lowest set bit of the rotated vector is the first requester at/after ptr.
   always_comb begin
      rot_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_off = IDX_W'(i);
         end
      end
   end

   assign idx = rot_off + ptr;
   assign any = |req;

endmodule

`default_nettype wire

// File: rtl/decoder_sel_arbiter.sv
// ============================================================================
// Module   : decoder_sel_arbiter
// Purpose  : Round-robin 4-way arbiter driving the select/enable of a 2-to-4
//            one-hot decoder. Holds a grant until done or timeout, and always
//            inserts a one-cycle gap between grants (break-before-make).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_sel_arbiter
   import decoder_sel_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [IDX_W-1:0]   sel,
   output logic               en,
   output logic               busy,
   output logic               timeout
);

   // Last hold-count value before a forced release (unused when TIMEOUT==0).
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q,   ptr_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [IDX_W-1:0]   sel_q,   sel_d;
   logic               en_q,    en_d;
   logic               busy_q,  busy_d;
   logic               timeout_q, timeout_d;

   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               hold_expired;

   rr_pick4 u_pick (
      .req (req),
      .ptr (ptr_q),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign hold_expired = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   // State and output registers; reset is asynchronous so en drops at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         sel_q     <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state: done wins over the hold limit, GAP always lasts one cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any)              state_d = GRANT;
         GRANT:   if (done || hold_expired)  state_d = GAP;
         GAP:                                state_d = IDLE;
         default:                            state_d = IDLE;
      endcase
   end

   // Register next-values: latch winner, count hold, advance ptr on release.
   always_comb begin
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d = pick_idx;
               cnt_d = '0;
            end
         end
         GRANT: begin
            if (done) begin
               ptr_d = wrap_inc(sel_q);
            end else if (hold_expired) begin
               ptr_d     = wrap_inc(sel_q);
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
      en_d   = (state_d == GRANT);
      busy_d = (state_d != IDLE);
   end

   assign sel     = sel_q;
   assign en      = en_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_sel_arbiter.sv
// ============================================================================
// Module   : tb_decoder_sel_arbiter
// Purpose  : Self-checking bench for decoder_sel_arbiter: directed scenarios
//            followed by random traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_sel_arbiter;

   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [1:0] sel;
   logic       en;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   // Model: who owns the line set, for how many cycles, and the rotation point.
   int m_sel, m_ptr, m_hold;
   bit m_en, m_busy, m_to, m_gap;

   decoder_sel_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .sel     (sel),
      .en      (en),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_sel = 0; m_ptr = 0; m_hold = 0;
      m_en = 0; m_busy = 0; m_to = 0; m_gap = 0;
   endtask

   task automatic model_release(input bit forced);
      m_en   = 0;
      m_gap  = 1;
      m_busy = 1;
      m_to   = forced;
      m_ptr  = (m_sel + 1) % 4;
   endtask

   // One clock of the model, from the inputs present at the rising edge.
   task automatic model_update();
      m_to = 0;
      if (m_en) begin
         m_hold++;
         if (done)                                  model_release(1'b0);
         else if (TIMEOUT != 0 && m_hold == TIMEOUT) model_release(1'b1);
      end else if (m_gap) begin
         m_gap  = 0;
         m_busy = 0;
      end else if (req != 4'd0) begin
         for (int k = 0; k < 4; k++) begin
            if (req[(m_ptr + k) % 4]) begin
               m_sel = (m_ptr + k) % 4;
               break;
            end
         end
         m_en = 1; m_busy = 1; m_hold = 0;
      end
   endtask

   task automatic chk(input string tag);
      total++;
      assert (sel === 2'(m_sel)) else begin
         bad++; $error("FAIL %s sel: got %0d want %0d", tag, sel, m_sel);
      end
      total++;
      assert (en === m_en) else begin
         bad++; $error("FAIL %s en: got %0b want %0b", tag, en, m_en);
      end
      total++;
      assert (busy === m_busy) else begin
         bad++; $error("FAIL %s busy: got %0b want %0b", tag, busy, m_busy);
      end
      total++;
      assert (timeout === m_to) else begin
         bad++; $error("FAIL %s timeout: got %0b want %0b", tag, timeout, m_to);
      end
   endtask

   task automatic chk_val(input string tag, input int got, input int want);
      total++;
      assert (got === want) else begin
         bad++; $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_update();
      @(negedge clk);
      chk(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_seq[5];
      int en_run;
      rst_n = 1'b1; req = 4'd0; done = 1'b0;
      @(negedge clk);

      // Reset values, then a single request on index 2.
      do_reset();
      req = 4'b0100;
      step("grant2");
      chk_val("grant2_sel", int'(sel), 2);
      chk_val("grant2_en", int'(en), 1);
      req = 4'b0000; done = 1'b1;
      step("done2");
      chk_val("done2_en", int'(en), 0);
      done = 1'b0;
      step("gap2_idle");
      chk_val("ptr_after2", m_ptr, 3);

      // Fully loaded rotation from a fresh reset.
      do_reset();
      exp_seq = '{0, 1, 2, 3, 0};
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         step("rr_grant");
         chk_val("rr_sel", int'(sel), exp_seq[g]);
         done = 1'b1;
         step("rr_done");
         done = 1'b0;
         step("rr_gap");
         chk_val("rr_gap_en", int'(en), 0);
      end

      // Timeout: winner drops its request and never signals done.
      req = 4'b0001;
      step("to_grant");
      req = 4'b0000;
      en_run = 1;
      for (int c = 0; c < 40 && en; c++) begin
         step("to_hold");
         if (en) en_run++;
      end
      chk_val("to_en_run", en_run, TIMEOUT);
      chk_val("to_pulse", int'(timeout), 1);
      step("to_gap");
      chk_val("to_pulse_len", int'(timeout), 0);
      req = 4'b1001;
      step("to_next");
      chk_val("to_next_sel", int'(sel), 3);
      done = 1'b1;
      step("to_next_done");
      done = 1'b0;
      req = 4'b0000;
      step("to_next_gap");

      // done arrives on the same cycle the hold limit would fire.
      req = 4'b0010;
      step("co_grant");
      req = 4'b0000;
      for (int c = 0; c < TIMEOUT - 1; c++) step("co_hold");
      done = 1'b1;
      step("co_release");
      chk_val("co_en", int'(en), 0);
      chk_val("co_no_to", int'(timeout), 0);
      done = 1'b0;
      step("co_gap");

      // Asynchronous reset in the middle of a grant on index 3.
      req = 4'b1000;
      step("ar_grant");
      chk_val("ar_sel3", int'(sel), 3);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst");
      chk_val("ar_en_now", int'(en), 0);
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1001;
      step("ar_regrant");
      chk_val("ar_ptr0_sel", int'(sel), 0);
      done = 1'b1; req = 4'b0000;
      step("ar_done");
      done = 1'b0;
      step("ar_gap");

      // done while idle with no requests has no effect.
      done = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step("idle_done");
         chk_val("idle_done_busy", int'(busy), 0);
      end
      done = 1'b0;

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 9) == 0);
         step("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
